dma_block_sequencer: RTL
========================

Name: dma_block_sequencer

Overview:
- Downstream of the SD host DMA transfer-type decoder; consumes its 2-bit Transfer_Type code.
- Sequences a data transfer block by block: requests each block from the data-line engine, counts completions and signals end of transfer.
- Handles single, infinite, multiple and stop-multiple transfers, plus stop-at-block-gap and abort.

Parameters:
- CNT_W, 16, width of the block count register and counters.

Ports:
- CLK  input  1  system clock, rising edge
- RESET_L  input  1  asynchronous active-low reset
- Transfer_Type  input  2  00 single, 01 infinite, 10 multiple, 11 stop-multiple
- Block_Count  input  CNT_W  programmed number of blocks, sampled at Start
- Start  input  1  one-cycle transfer start pulse
- Block_Ack  input  1  data engine accepted the current block request
- Block_Done  input  1  one-cycle pulse, current block fully transferred
- Stop_Request  input  1  stop at next block gap; level or pulse
- Abort  input  1  immediate termination
- Busy  output  1  high from Start acceptance until return to IDLE
- Block_Req  output  1  request for the next block, held until Block_Ack
- Blocks_Remaining  output  CNT_W  blocks left, for multiple/stop-multiple transfers
- Blocks_Transferred  output  CNT_W  completed blocks in this transfer
- Transfer_Complete  output  1  one-cycle pulse, normal end of transfer
- Aborted  output  1  one-cycle pulse, transfer ended by Abort

Behaviour:
- Reset (async, RESET_L=0): state IDLE; all outputs 0; latched type, stop flag and counters cleared.
- All state and outputs are registered; outputs change only on the rising edge of CLK.
- States: IDLE, REQ, XFER, DONE.
- IDLE:
  - Start=1 latches Transfer_Type into type_q, loads Blocks_Remaining from Block_Count, clears Blocks_Transferred and the stop flag.
  - Next state is REQ, with Busy=1 and Block_Req=1 on the next cycle.
  - Exception: type_q=10 with Block_Count=0 goes to DONE instead; no block is requested.
- Start outside IDLE: ignored.
- REQ: Block_Req=1 held until Block_Ack=1. In that cycle go to XFER; Block_Req=0 from the next cycle.
- XFER: wait for Block_Done. When Block_Done=1:
  - Blocks_Transferred increments by 1 and wraps modulo 2^CNT_W with no flag.
  - For type 10 or 11, Blocks_Remaining decrements by 1 and saturates at 0.
  - Next-state decision:
    - type 00 or 11 -> DONE
    - type 10 with post-decrement remaining=0 -> DONE
    - stop flag set, or Stop_Request=1 this cycle -> DONE
    - otherwise -> REQ
- Block_Done outside XFER: ignored.
- Stop flag: set by Stop_Request=1 in any non-IDLE state; takes effect only at the next block boundary.
- Stop_Request=1 in REQ before Block_Ack: the current request still completes its block, then the transfer ends.
- DONE: Transfer_Complete=1 for exactly one cycle, Busy=0 the same cycle, next state IDLE.
- Counters hold their final values until the next accepted Start.
- Abort=1 in any non-IDLE state:
  - Next state IDLE; Aborted=1 for one cycle; Block_Req=0 and Busy=0 the same cycle.
  - Counters hold their current values.
  - Abort has priority over Block_Done, Block_Ack and Stop_Request in the same cycle.
- Abort in IDLE: ignored, no Aborted pulse.
- Latency:
  - Start to Block_Req: 1 cycle.
  - Block_Done to next Block_Req: 1 cycle.
  - Final Block_Done to Transfer_Complete: 1 cycle.
- Transfer_Type and Block_Count changes after Start have no effect on the current transfer.

Test Plan:
- Single: type=00, Start, Ack on cycle 2, Block_Done 5 cycles later -> exactly one Block_Req; Transfer_Complete 1 cycle after Block_Done; Blocks_Transferred=1.
- Multiple: type=10, Block_Count=3, immediate Ack, Block_Done after each request -> three Block_Req; Blocks_Remaining goes 3,2,1,0; one Transfer_Complete; Blocks_Transferred=3.
- Zero count: type=10, Block_Count=0, Start -> no Block_Req; Transfer_Complete 2 cycles after Start; Busy high for 1 cycle.
- Infinite with stop: type=01, run 5 blocks, pulse Stop_Request mid-block 6 -> block 6 completes, then Transfer_Complete; Blocks_Transferred=6; no 7th request.
- Abort: type=10, Block_Count=4, Abort asserted the same cycle as Block_Done of block 2 -> Aborted pulse; no Transfer_Complete; Blocks_Transferred=1; IDLE the next cycle.
- Reset mid-transfer: RESET_L low during XFER between clock edges -> all outputs 0 immediately; a new Start after release behaves as from power-up.

Source files
------------

// File: rtl/dma_block_sequencer_if.sv
// Handshake and status bundle between the DMA block sequencer and its controller.
// The sequencer connects through the slave modport; the driving side uses master.
interface dma_block_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       Transfer_Type;
  logic [CNT_W-1:0] Block_Count;
  logic             Start;
  logic             Block_Ack;
  logic             Block_Done;
  logic             Stop_Request;
  logic             Abort;
  logic             Busy;
  logic             Block_Req;
  logic [CNT_W-1:0] Blocks_Remaining;
  logic [CNT_W-1:0] Blocks_Transferred;
  logic             Transfer_Complete;
  logic             Aborted;

  modport slave (
    input  Transfer_Type, Block_Count, Start, Block_Ack, Block_Done, Stop_Request, Abort,
    output Busy, Block_Req, Blocks_Remaining, Blocks_Transferred, Transfer_Complete, Aborted
  );

  modport master (
    output Transfer_Type, Block_Count, Start, Block_Ack, Block_Done, Stop_Request, Abort,
    input  Busy, Block_Req, Blocks_Remaining, Blocks_Transferred, Transfer_Complete, Aborted
  );
endinterface

// File: rtl/dma_block_sequencer.sv
// Block-by-block transfer sequencer: requests blocks from the data-line engine,
// counts completions and reports normal completion or abort.
module dma_block_sequencer #(
  parameter int CNT_W = 16
) (
  input logic                  CLK,
  input logic                  RESET_L,
  dma_block_sequencer_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] T_SINGLE = 2'b00;
  localparam logic [1:0] T_MULTI  = 2'b10;
  localparam logic [1:0] T_STOPM  = 2'b11;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [1:0]       r_type;
  logic             r_stop;
  logic             r_busy;
  logic             r_req;
  logic             r_tc;
  logic             r_abt;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_xfd;

  logic [CNT_W-1:0] w_rem_dec;
  logic             w_last;

  assign w_rem_dec = (r_rem == '0) ? '0 : (r_rem - ONE);

  always_comb begin
    w_last = 1'b0;
    if ((r_type == T_SINGLE) || (r_type == T_STOPM))
      w_last = 1'b1;
    else if ((r_type == T_MULTI) && (w_rem_dec == '0))
      w_last = 1'b1;
    else if (r_stop || bus.Stop_Request)
      w_last = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state <= S_IDLE;
      r_type  <= 2'b00;
      r_stop  <= 1'b0;
      r_busy  <= 1'b0;
      r_req   <= 1'b0;
      r_tc    <= 1'b0;
      r_abt   <= 1'b0;
      r_rem   <= '0;
      r_xfd   <= '0;
    end else begin
      r_tc  <= 1'b0;
      r_abt <= 1'b0;
      if ((r_state != S_IDLE) && bus.Abort) begin
        r_state <= S_IDLE;
        r_abt   <= 1'b1;
        r_req   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        if ((r_state != S_IDLE) && bus.Stop_Request)
          r_stop <= 1'b1;
        case (r_state)
          S_IDLE: begin
            if (bus.Start) begin
              r_type <= bus.Transfer_Type;
              r_rem  <= bus.Block_Count;
              r_xfd  <= '0;
              r_stop <= 1'b0;
              r_busy <= 1'b1;
              if ((bus.Transfer_Type == T_MULTI) && (bus.Block_Count == '0)) begin
                r_state <= S_DONE;
              end else begin
                r_state <= S_REQ;
                r_req   <= 1'b1;
              end
            end
          end
          S_REQ: begin
            if (bus.Block_Ack) begin
              r_state <= S_XFER;
              r_req   <= 1'b0;
            end
          end
          S_XFER: begin
            if (bus.Block_Done) begin
              r_xfd <= r_xfd + ONE;
              if (r_type[1])
                r_rem <= w_rem_dec;
              if (w_last) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_tc    <= 1'b1;
              end else begin
                r_state <= S_REQ;
                r_req   <= 1'b1;
              end
            end
          end
          S_DONE: begin
            // A zero-count transfer arrives here still busy and pulses on exit;
            // a normal completion already pulsed on entry.
            r_state <= S_IDLE;
            r_tc    <= r_busy;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Busy               = r_busy;
  assign bus.Block_Req          = r_req;
  assign bus.Transfer_Complete  = r_tc;
  assign bus.Aborted            = r_abt;
  assign bus.Blocks_Remaining   = r_rem;
  assign bus.Blocks_Transferred = r_xfd;
endmodule
